// File: rtl/bridge_tx.sv
// Transmit half of the UART bridge: turns 16-bit bus read responses into
// ASCII replies "M" + 4 hex digits + CR [+ LF] on a byte valid/ready stream.
module bridge_tx #(
  parameter bit         APPEND_LF = 1'b1,
  parameter logic [7:0] RESP_CHAR = 8'h4D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_i,
  input  logic        rw_i,
  input  logic        valid_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        drop_o
);

  localparam int unsigned MSG_LEN  = APPEND_LF ? 7 : 6;
  localparam logic [2:0]  LAST_IDX = 3'(MSG_LEN - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] act_q, act_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        drop_q, drop_d;
  logic [7:0]  msg_byte;

  logic resp_evt;
  logic handshake;
  logic last_hs;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign resp_evt  = valid_i && !rw_i;
  assign handshake = (state_q == SEND) && ready_i;
  assign last_hs   = handshake && (idx_q == LAST_IDX);

  always_comb begin
    case (idx_q)
      3'd0:    msg_byte = RESP_CHAR;
      3'd1:    msg_byte = hex_ascii(act_q[15:12]);
      3'd2:    msg_byte = hex_ascii(act_q[11:8]);
      3'd3:    msg_byte = hex_ascii(act_q[7:4]);
      3'd4:    msg_byte = hex_ascii(act_q[3:0]);
      3'd5:    msg_byte = 8'h0D;
      default: msg_byte = 8'h0A;
    endcase
  end

  assign byte_o  = (state_q == SEND) ? msg_byte : 8'h00;
  assign valid_o = (state_q == SEND);
  assign busy_o  = (state_q == SEND);
  assign drop_o  = drop_q;

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch so no latch is inferred.
    state_d    = state_q;
    idx_d      = idx_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (resp_evt) begin
          state_d = SEND;
          idx_d   = 3'd0;
          act_d   = data_i;
        end
      end
      SEND: begin
        if (last_hs) begin
          idx_d = 3'd0;
          if (pend_vld_q) begin
            // Pending promotes; the freed pending slot can take a same-edge response.
            act_d      = pend_q;
            pend_vld_d = resp_evt;
            if (resp_evt) pend_d = data_i;
          end else if (resp_evt) begin
            act_d = data_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (handshake) idx_d = idx_q + 3'd1;
          if (resp_evt) begin
            if (!pend_vld_q) begin
              pend_d     = data_i;
              pend_vld_d = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 3'd0;
      act_q      <= 16'h0000;
      pend_q     <= 16'h0000;
      pend_vld_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q    <= state_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_bridge_tx.sv
// Self-checking bench for bridge_tx: a queue-based reply model predicts the
// byte stream, busy and drop cycle by cycle for both CR+LF and CR-only builds.
module tb_bridge_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_i = 16'h0000;
  logic        rw_i = 1'b0;
  logic        vin = 1'b0;
  logic        ready_i = 1'b0;
  logic        sel0 = 1'b0;

  logic        valid_lf, valid_cr;
  logic [7:0]  byte_lf, byte_cr;
  logic        vo_lf, vo_cr, busy_lf, busy_cr, drop_lf, drop_cr;

  int n_chk  = 0;
  int n_fail = 0;

  assign valid_lf = vin && !sel0;
  assign valid_cr = vin && sel0;

  bridge_tx #(.APPEND_LF(1'b1), .RESP_CHAR(8'h4D)) dut (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_lf),
    .byte_o(byte_lf), .valid_o(vo_lf), .ready_i(ready_i), .busy_o(busy_lf), .drop_o(drop_lf)
  );

  bridge_tx #(.APPEND_LF(1'b0), .RESP_CHAR(8'h4D)) dut_cr (
    .clk(clk), .rst_n(rst_n), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_cr),
    .byte_o(byte_cr), .valid_o(vo_cr), .ready_i(ready_i), .busy_o(busy_cr), .drop_o(drop_cr)
  );

  always #5 clk = ~clk;

  // Observed {valid, busy, drop, byte}; byte is only meaningful while valid.
  logic [10:0] obs;
  assign obs = sel0 ? {vo_cr, busy_cr, drop_cr, vo_cr ? byte_cr : 8'h00}
                    : {vo_lf, busy_lf, drop_lf, vo_lf ? byte_lf : 8'h00};

  // Reference model: queue of buffered words (head is the active reply).
  logic [15:0] mq[$];
  int          mpos = 0;
  bit          mdrop = 1'b0;
  int          mlen = 7;

  function automatic logic [7:0] hex_char(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  function automatic logic [7:0] reply_byte(input logic [15:0] w, input int p);
    case (p)
      0:       return 8'h4D;
      1:       return hex_char(int'(w[15:12]));
      2:       return hex_char(int'(w[11:8]));
      3:       return hex_char(int'(w[7:4]));
      4:       return hex_char(int'(w[3:0]));
      5:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  function automatic logic [10:0] exp_vec();
    logic v;
    v = (mq.size() > 0);
    return {v, v, mdrop, v ? reply_byte(mq[0], mpos) : 8'h00};
  endfunction

  task automatic model_reset();
    mq.delete();
    mpos  = 0;
    mdrop = 1'b0;
  endtask

  task automatic model_update();
    mdrop = 1'b0;
    if (mq.size() > 0 && ready_i) begin
      mpos++;
      if (mpos == mlen) begin
        void'(mq.pop_front());
        mpos = 0;
      end
    end
    if (vin && !rw_i) begin
      if (mq.size() < 2) mq.push_back(data_i);
      else mdrop = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs !== 11'h000 || byte_lf !== 8'h00 || byte_cr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset: got %h byte %h/%h, want 000 byte 00/00", obs, byte_lf, byte_cr);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [7:0] want[7] = '{8'h4D, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
    logic [7:0] got[$];
    ready_i = 1'b1;
    data_i  = 16'h1234;
    vin     = 1'b1;
    step();
    vin = 1'b0;
    for (int c = 0; c < 10; c++) begin
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL single cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      if (vo_lf && ready_i) got.push_back(byte_lf);
      data_i = 16'($urandom);
      step();
    end
    n_chk++;
    if (got.size() != 7) begin
      n_fail++;
      $display("FAIL single_len: got %0d bytes want 7", got.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_chk++;
        if (got[i] !== want[i]) begin
          n_fail++;
          $display("FAIL single_byte %0d: got %h want %h", i, got[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    data_i  = 16'hABCF;
    vin     = 1'b1;
    ready_i = 1'b1;
    step();
    vin = 1'b0;
    for (int c = 0; c < 20; c++) begin
      ready_i = (c % 4 == 0) || (c % 4 == 3);
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL backpressure cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_write_ignored();
    ready_i = 1'b1;
    data_i  = 16'hFFFF;
    rw_i    = 1'b1;
    vin     = 1'b1;
    step();
    vin  = 1'b0;
    rw_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_chk++;
      if (obs !== exp_vec() || obs !== 11'h000) begin
        n_fail++;
        $display("FAIL write_ignored cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    ready_i = 1'b0;
    for (int c = 0; c < 24; c++) begin
      vin = (c < 3);
      data_i = 16'(c + 1);
      if (c == 5) ready_i = 1'b1;
      step();
      if (drop_lf) drops++;
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL back_to_back cyc %0d: got %h want %h", c, obs, exp_vec());
      end
    end
    n_chk++;
    if (drops != 1) begin
      n_fail++;
      $display("FAIL drop_count: got %0d want 1", drops);
    end
  endtask

  task automatic test_no_lf();
    sel0    = 1'b1;
    mlen    = 6;
    ready_i = 1'b1;
    data_i  = 16'h00FF;
    vin     = 1'b1;
    step();
    vin = 1'b0;
    for (int c = 0; c < 9; c++) begin
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL no_lf cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      step();
    end
    sel0 = 1'b0;
    mlen = 7;
  endtask

  task automatic test_reset_mid();
    ready_i = 1'b1;
    data_i  = 16'h9ABC;
    vin     = 1'b1;
    step();
    vin = 1'b0;
    repeat (3) step();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (vo_lf !== 1'b0 || busy_lf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got valid %b busy %b want 0 0", vo_lf, busy_lf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got %h want %h", c, obs, exp_vec());
      end
    end
    data_i = 16'h5678;
    vin    = 1'b1;
    step();
    vin = 1'b0;
    for (int c = 0; c < 9; c++) begin
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_fresh cyc %0d: got %h want %h", c, obs, exp_vec());
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      vin     = ($urandom_range(0, 2) == 0);
      rw_i    = ($urandom_range(0, 4) == 0);
      data_i  = 16'($urandom);
      ready_i = ($urandom_range(0, 2) != 0);
      step();
      n_chk++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", c, obs, exp_vec());
      end
    end
    vin  = 1'b0;
    rw_i = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_write_ignored();
    test_back_to_back();
    test_no_lf();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bridge_tx.md
Name: bridge_tx

Overview:
- Transmit half of the UART bridge. Takes read-response words returned by the on-chip bus and serialises each one as an ASCII hex reply to the host.
- Reply format: "M" + 4 uppercase hex digits (MSB nibble first) + CR [+ LF].
- Drives a byte-wide valid/ready stream into the UART transmitter.
- Holds one active message plus one pending response, so back-to-back reads are not lost.

Parameters:
- APPEND_LF, 1: 1 = terminate the reply with 0x0D 0x0A (7 bytes); 0 = 0x0D only (6 bytes).
- RESP_CHAR, 8'h4D: leading byte of every reply ("M").

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_i  input  16  read data from the bus.
- rw_i  input  1  0 = read response, 1 = write acknowledge (ignored).
- valid_i  input  1  single-cycle qualifier for data_i/rw_i.
- byte_o  output  8  ASCII byte to the UART transmitter.
- valid_o  output  1  byte_o is valid.
- ready_i  input  1  UART accepts byte_o this cycle when valid_o && ready_i.
- busy_o  output  1  active message in progress.
- drop_o  output  1  one-cycle pulse: a read response was discarded.

Behaviour:
- Reset (asynchronous, while rst_n low):
  - byte_o=0, valid_o=0, busy_o=0, drop_o=0.
  - Active and pending slots empty; byte index = 0.
  - A message in flight is abandoned with no partial completion after release.
- Capture: a cycle with valid_i && !rw_i is a "response event". valid_i with rw_i=1 is ignored entirely (no drop_o).
- Slot rules for a response event, evaluated on the same edge:
  - Active slot free after this edge → load the active slot.
  - Else pending slot free after this edge → load the pending slot.
  - Else discard and pulse drop_o for 1 cycle.
  - "Free after this edge" counts a slot vacated on the same edge: the final-byte handshake vacates active, and pending then promotes to active.
- Message states: IDLE, SEND with byte index 0..N-1 (N = 7 if APPEND_LF, else 6).
  - Byte sequence: RESP_CHAR, hex(d[15:12]), hex(d[11:8]), hex(d[7:4]), hex(d[3:0]), 0x0D, [0x0A].
  - hex(n): n ≤ 9 → 0x30+n; n ≥ 10 → 0x41+n-10 (uppercase only).
- Latency: response event at edge k → valid_o=1 with byte_o=RESP_CHAR from edge k (visible the cycle after valid_i).
- Handshake:
  - While valid_o=1, byte_o is held stable until valid_o && ready_i.
  - The index advances only on a handshake.
  - valid_o never drops before its handshake.
  - ready_i while valid_o=0 has no effect.
- End of message (handshake on index N-1):
  - Pending full → pending promotes to active, index=0, and valid_o stays 1 with byte_o=RESP_CHAR on the next cycle (no gap).
  - Else, if a response event arrives the same cycle, it becomes active with no gap.
  - Otherwise valid_o=0, busy_o=0, state IDLE.
- busy_o = 1 exactly while the active slot is occupied.
- Incoming data is never modified after capture; a later data_i change does not affect queued words.
- Throughput: at most 2 responses buffered; a third response arriving while both slots are full is dropped.

Test Plan:
- Single read: data_i=16'h1234, rw_i=0, valid_i pulse, ready_i=1 held → byte_o sequence 4D 31 32 33 34 0D 0A on 7 consecutive cycles, then valid_o=0, busy_o=0.
- Hex letters and backpressure: data_i=16'hABCF, ready_i toggling 1-0-0-1 … → bytes 4D 41 42 43 46 0D 0A; byte_o stable across every ready_i=0 cycle.
- Write ignored: valid_i with rw_i=1, data_i=16'hFFFF → valid_o stays 0, drop_o stays 0.
- Back-to-back plus drop: three reads (0x0001, 0x0002, 0x0003) on consecutive cycles with ready_i=0 → drop_o pulses once on the third; releasing ready_i yields "M0001\r\n" immediately followed by "M0002\r\n" with no idle cycle.
- APPEND_LF=0: read 16'h00FF → bytes 4D 30 30 46 46 0D, then idle.
- Reset mid-message: assert rst_n=0 after byte 3 of a reply → valid_o=0 asynchronously; after release with no new valid_i, valid_o stays 0; a fresh read 16'h5678 then produces the full "M5678\r\n".
